// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - multi-cycle chunked signed/unsigned magnitude comparator
// Optional feature macro: CMP_EARLY_EXIT_EN (stop at first differing chunk).
module comparator_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Result encoding is {eq, gt, lt}; all-zero means "no decision".
    localparam logic [2:0] R_NONE = 3'b000;
    localparam logic [2:0] R_EQ   = 3'b100;
    localparam logic [2:0] R_GT   = 3'b010;
    localparam logic [2:0] R_LT   = 3'b001;

    logic [0:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       res_q, res_d;
    logic             done_q, done_d;
`ifndef CMP_EARLY_EXIT_EN
    logic [2:0]       pend_q, pend_d;
`endif

    logic [CHUNK-1:0] a_chk, b_chk;
    logic [2:0]       chunk_res;
    logic             last;

    always_comb begin
        a_chk = '0;
        b_chk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chk = a_q[i*CHUNK +: CHUNK];
                b_chk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign chunk_res = (a_chk > b_chk) ? R_GT : ((a_chk < b_chk) ? R_LT : R_EQ);
    assign last      = (idx_q == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        done_d  = 1'b0;
`ifndef CMP_EARLY_EXIT_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Flipping both MSBs maps two's-complement order onto unsigned order.
                    a_d     = a ^ (signed_mode ? MSB_MASK : '0);
                    b_d     = b ^ (signed_mode ? MSB_MASK : '0);
                    idx_d   = IDX_TOP;
                    state_d = S_RUN;
`ifndef CMP_EARLY_EXIT_EN
                    pend_d  = R_NONE;
`endif
                end
            end
            S_RUN: begin
`ifdef CMP_EARLY_EXIT_EN
                if (chunk_res != R_EQ || last) begin
                    res_d   = chunk_res;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
`else
                if (last) begin
                    res_d   = (pend_q != R_NONE) ? pend_q : chunk_res;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                    if (pend_q == R_NONE && chunk_res != R_EQ) begin
                        pend_d = chunk_res;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= R_NONE;
            done_q  <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            pend_q  <= R_NONE;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            done_q  <= done_d;
`ifndef CMP_EARLY_EXIT_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign busy         = (state_q == S_RUN);
    assign done         = done_q;
    assign {eq, gt, lt} = res_q;
endmodule

// File: tb/tb_comparator_seq.sv
// tb/tb_comparator_seq.sv - randomized + directed bench for comparator_seq against a behavioural model
module tb_comparator_seq;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sm = 1'b0;
    logic             busy, done, eq, gt, lt;

    int tests = 0;
    int fails = 0;

    comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(sm),
        .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
    );

    always #5 clk = ~clk;

    function automatic int lat(input int k);
`ifdef CMP_EARLY_EXIT_EN
        return k;
`else
        return NCHUNK;
`endif
    endfunction

    function automatic int lead_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int k = 1;
        for (int i = NCHUNK - 1; i >= 1; i--) begin
            if (x[i*CHUNK +: CHUNK] != y[i*CHUNK +: CHUNK]) break;
            k++;
        end
        return k;
    endfunction

    function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s);
        if (x == y) return 3'b100;
        if (s) return ($signed(x) > $signed(y)) ? 3'b010 : 3'b001;
        return (x > y) ? 3'b010 : 3'b001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted start schedules a result a fixed number of edges later.
    logic       m_busy = 1'b0, m_done = 1'b0;
    logic [2:0] m_res = 3'b000, m_pend = 3'b000;
    int         m_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_res = 3'b000; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_res = m_pend;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_cnt  = lat(lead_k(a, b));
                m_pend = ref_res(a, b, sm);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("outputs{busy,done,eq,gt,lt}", {27'd0, busy, done, eq, gt, lt},
            {27'd0, m_busy, m_done, m_res});
    end

    task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; sm = s; start = 1'b1;
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        @(posedge clk);
        #1;
        start = 1'b0;
        bcnt = int'(busy);
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            bcnt += int'(busy);
            if (cyc > 40) begin
                chk("wait_done_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    task automatic run_cmp(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic s, input logic [2:0] exp_res, input int exp_k);
        int cyc, bcnt;
        start_op(x, y, s);
        wait_done(cyc, bcnt);
        chk({name, "_latency"}, cyc, lat(exp_k));
        chk({name, "_busy_cycles"}, bcnt, lat(exp_k));
        chk({name, "_result"}, {29'd0, eq, gt, lt}, {29'd0, exp_res});
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        rst = 1'b0;

        run_cmp("eq_1234", 16'h1234, 16'h1234, 1'b0, 3'b100, 4);
        run_cmp("gt_5000", 16'h5000, 16'h3000, 1'b0, 3'b010, 1);
        run_cmp("signed_ffff", 16'hFFFF, 16'h0001, 1'b1, 3'b001, 1);
        run_cmp("unsigned_ffff", 16'hFFFF, 16'h0001, 1'b0, 3'b010, 1);
        run_cmp("signed_8000", 16'h8000, 16'h7FFF, 1'b1, 3'b001, 1);

        // start held into the busy cycle with new operands must be ignored
        start_op(16'd5, 16'd3, 1'b0);
        @(posedge clk);
        #1;
        a = 16'd3; b = 16'd5;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        chk("hold_start_done_count", n, 1);
        chk("hold_start_result", {29'd0, eq, gt, lt}, 32'b010);

        // reset mid-operation aborts with no done
        start_op(16'h1230, 16'h1231, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_reset_outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        chk("abort_no_done", n, 0);
        run_cmp("after_reset_lt", 16'd3, 16'd5, 1'b0, 3'b001, 4);

        // start in the done cycle is accepted
        run_cmp("b2b_first_eq", 16'd7, 16'd7, 1'b0, 3'b100, 4);
        chk("b2b_in_done_cycle", {31'd0, done}, 32'd1);
        run_cmp("b2b_second_gt", 16'd9, 16'd2, 1'b0, 3'b010, 4);

        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] mask;
            @(negedge clk);
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       mask = '0;
                1:       mask = WIDTH'($urandom) & 16'h000F;
                2:       mask = WIDTH'($urandom) & 16'h00FF;
                default: mask = WIDTH'($urandom);
            endcase
            a     = ra;
            b     = ra ^ mask;
            sm    = 1'($urandom);
            start = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
